rcc_div_ramp_ctrl: RTL and testbench

RCC_DIV_RAMP_CTRL -- requirements
Module: rcc_div_ramp_ctrl

---
 rtl/rcc_div_pkg.sv | 36 +++
 rtl/rcc_div_settle_mon.sv | 38 +++
 rtl/rcc_div_ramp_ctrl.sv | 108 ++++++++++
 tb/tb_rcc_div_ramp_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rcc_div_pkg.sv
// rtl/rcc_div_pkg.sv - shared ratio codes, level conversions, FSM states and defaults
package rcc_div_pkg;

  localparam int DEF_SETTLE_PULSES = 4;
  localparam int DEF_TIMEOUT_CYC   = 2048;

  localparam logic [3:0] DIV_1   = 4'b0000;
  localparam logic [3:0] DIV_2   = 4'b1000;
  localparam logic [3:0] DIV_4   = 4'b1001;
  localparam logic [3:0] DIV_8   = 4'b1010;
  localparam logic [3:0] DIV_16  = 4'b1011;
  localparam logic [3:0] DIV_64  = 4'b1100;
  localparam logic [3:0] DIV_128 = 4'b1101;
  localparam logic [3:0] DIV_256 = 4'b1110;
  localparam logic [3:0] DIV_512 = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_SETTLE
  } rcc_state_e;

  // Codes 1xxx are laid out so that the low three bits are simply level-1.
  function automatic logic [3:0] code2lvl(input logic [3:0] code);
    if (code[3]) return {1'b0, code[2:0]} + 4'd1;
    return 4'd0;
  endfunction

  function automatic logic [3:0] lvl2code(input logic [3:0] lvl);
    logic [3:0] w_m1;
    w_m1 = lvl - 4'd1;
    if (lvl == 4'd0) return DIV_1;
    return {1'b1, w_m1[2:0]};
  endfunction

endpackage

// File: rtl/rcc_div_settle_mon.sv
// rtl/rcc_div_settle_mon.sv - counts divider pulses after a step and flags a stalled divider
module rcc_div_settle_mon
  import rcc_div_pkg::*;
#(
  parameter int SETTLE_PULSES = DEF_SETTLE_PULSES,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
  input  logic i_clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_div_en,
  output logic o_settled,
  output logic o_timeout
);

  logic [3:0]  r_pulse_cnt;
  logic [15:0] r_to_cnt;

  always_ff @(posedge i_clk) begin
    if (rst || i_clear) begin
      r_pulse_cnt <= 4'd0;
      r_to_cnt    <= 16'd0;
    end else if (i_enable) begin
      if (i_div_en) begin
        if (r_pulse_cnt != 4'hF) r_pulse_cnt <= r_pulse_cnt + 4'd1;
        r_to_cnt <= 16'd0;
      end else if (r_to_cnt != 16'hFFFF) begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
    end
  end

  // Both flags fire on the edge that would make the count reach its limit.
  assign o_settled = i_enable && i_div_en && (r_pulse_cnt == 4'(SETTLE_PULSES - 1));
  assign o_timeout = i_enable && !i_div_en && (r_to_cnt >= 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/rcc_div_ramp_ctrl.sv
// rtl/rcc_div_ramp_ctrl.sv - ramps the divider select one level at a time toward a requested ratio
module rcc_div_ramp_ctrl
  import rcc_div_pkg::*;
#(
  parameter int SETTLE_PULSES = DEF_SETTLE_PULSES,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_sel,
  output logic       req_ready,
  input  logic       div_en,
  output logic [3:0] div_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  rcc_state_e r_state, w_state_nxt;
  logic [3:0] r_level, w_level_nxt;
  logic [3:0] r_target, w_target_nxt;
  logic [3:0] r_div_sel;
  logic       r_done, w_done_nxt;
  logic       r_err, w_err_nxt;
  logic       w_accept;
  logic [3:0] w_req_lvl;
  logic       w_settled;
  logic       w_timeout;

  rcc_div_settle_mon #(
    .SETTLE_PULSES(SETTLE_PULSES),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) u_settle_mon (
    .i_clk    (i_clk),
    .rst      (rst),
    .i_clear  (r_state == ST_STEP),
    .i_enable (r_state == ST_SETTLE),
    .i_div_en (div_en),
    .o_settled(w_settled),
    .o_timeout(w_timeout)
  );

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_req_lvl = code2lvl(req_sel);

  always_comb begin
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_target_nxt = r_target;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_target_nxt = w_req_lvl;
          w_err_nxt    = 1'b0;
          if (w_req_lvl == r_level) w_done_nxt  = 1'b1;
          else                      w_state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        w_level_nxt = (r_target > r_level) ? r_level + 4'd1 : r_level - 4'd1;
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        // A pulse on the timeout edge counts as progress, so settle wins.
        if (w_settled) begin
          if (r_level != r_target) begin
            w_state_nxt = ST_STEP;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else if (w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_level   <= 4'd0;
      r_target  <= 4'd0;
      r_div_sel <= DIV_1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_level   <= w_level_nxt;
      r_target  <= w_target_nxt;
      r_div_sel <= lvl2code(w_level_nxt);
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign div_sel = r_div_sel;
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign err     = r_err;

endmodule

// File: tb/tb_rcc_div_ramp_ctrl.sv
// tb/tb_rcc_div_ramp_ctrl.sv - directed ramp scenarios with a div_sel step scoreboard
module tb_rcc_div_ramp_ctrl;

  localparam int SETTLE = 4;
  localparam int TOUT   = 2048;

  logic       i_clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_sel = 4'h0;
  logic       req_ready;
  logic       div_en = 1'b0;
  logic [3:0] div_sel;
  logic       busy;
  logic       done;
  logic       err;

  rcc_div_ramp_ctrl #(.SETTLE_PULSES(SETTLE), .TIMEOUT_CYC(TOUT)) dut (
    .i_clk    (i_clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_sel  (req_sel),
    .req_ready(req_ready),
    .div_en   (div_en),
    .div_sel  (div_sel),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 i_clk = ~i_clk;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [3:0] exp_q[$];
  int         m_level = 0;
  int         done_cnt = 0;
  int         d0 = 0;
  int         held = 0;
  int         phase = 0;
  logic [3:0] last_sel = 4'h0;
  bit         mon_on = 0;
  bit         first_step = 0;
  bit         en_mode = 1;
  bit         hold_req = 0;

  function automatic logic [3:0] code_of(input int l);
    case (l)
      1: return 4'b1000;
      2: return 4'b1001;
      3: return 4'b1010;
      4: return 4'b1011;
      5: return 4'b1100;
      6: return 4'b1101;
      7: return 4'b1110;
      8: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int lvl_of(input logic [3:0] c);
    for (int l = 1; l <= 8; l++) if (code_of(l) == c) return l;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: sample after the edge, score div_sel changes, then drive div_en.
  task automatic tick();
    int e;
    @(posedge i_clk);
    #1;
    if (done === 1'b1) done_cnt++;
    if (div_sel !== last_sel) begin
      if (mon_on) begin
        e = -1;
        if (exp_q.size() > 0) e = int'(exp_q.pop_front());
        chk("div_sel_step", int'(div_sel), e);
        if (!first_step) chk("hold_pulses", int'(held >= SETTLE), 1);
        first_step = 0;
      end
      held = 0;
      last_sel = div_sel;
    end else if (div_en) begin
      held++;
    end
    if (hold_req && busy === 1'b1) chk("ready_while_busy", int'(req_ready), 0);
    phase++;
    div_en = en_mode && (phase % 4 == 0);
  endtask

  task automatic do_req(input logic [3:0] sel);
    int tgt;
    chk("req_ready_idle", int'(req_ready), 1);
    d0 = done_cnt;
    first_step = 1;
    tgt = lvl_of(sel);
    while (m_level != tgt) begin
      m_level += (tgt > m_level) ? 1 : -1;
      exp_q.push_back(code_of(m_level));
    end
    req_valid = 1'b1;
    req_sel = sel;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic finish_ramp(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy === 1'b1 && n < budget);
    req_valid = 1'b0;
    hold_req = 0;
    chk("idle_in_budget", int'(n < budget), 1);
    chk("sb_drained", exp_q.size(), 0);
    chk("done_once", done_cnt - d0, 1);
    chk("busy_end", int'(busy), 0);
    chk("err_end", int'(err), 0);
    chk("final_sel", int'(div_sel), int'(code_of(m_level)));
  endtask

  initial begin
    int dr;
    repeat (3) tick();
    chk("rst_div_sel", int'(div_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(req_ready), 0);
    rst = 1'b0;
    #1;
    last_sel = div_sel;
    mon_on = 1;

    // Ramp 0 -> /8 in the first cycle after reset.
    do_req(4'b1010);
    chk("busy_after_accept", int'(busy), 1);
    finish_ramp(1000);

    // Up to /512, then all the way down with a 0xxx code.
    do_req(4'b1111);
    finish_ramp(1000);
    do_req(4'b0101);
    finish_ramp(2000);

    // Same-level request at /16.
    do_req(4'b1011);
    finish_ramp(1000);
    do_req(4'b1011);
    chk("same_done", int'(done), 1);
    chk("same_busy", int'(busy), 0);
    chk("same_sel", int'(div_sel), 4'b1011);
    tick();
    chk("same_done_clr", int'(done), 0);
    chk("same_busy2", int'(busy), 0);

    // Settle timeout on the first step toward /64.
    do_req(4'b0000);
    finish_ramp(1000);
    en_mode = 0;
    div_en = 1'b0;
    do_req(4'b1100);
    tick();
    chk("to_first_step", int'(div_sel), 4'b1000);
    repeat (TOUT - 1) tick();
    chk("to_err_early", int'(err), 0);
    chk("to_busy_early", int'(busy), 1);
    tick();
    chk("to_err", int'(err), 1);
    chk("to_busy", int'(busy), 0);
    chk("to_sel_hold", int'(div_sel), 4'b1000);
    chk("to_no_done", done_cnt - d0, 0);
    exp_q.delete();
    m_level = 1;
    en_mode = 1;
    do_req(4'b1000);
    chk("err_cleared", int'(err), 0);
    chk("clr_done", int'(done), 1);

    // Reset in the middle of a ramp to /256.
    do_req(4'b1110);
    repeat (40) tick();
    chk("mid_busy", int'(busy), 1);
    dr = done_cnt;
    mon_on = 0;
    rst = 1'b1;
    tick();
    chk("abort_sel", int'(div_sel), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err), 0);
    rst = 1'b0;
    #1;
    exp_q.delete();
    m_level = 0;
    last_sel = div_sel;
    mon_on = 1;
    do_req(4'b1001);
    chk("post_rst_accept", int'(busy), 1);
    chk("abort_no_done", done_cnt - dr, 0);
    finish_ramp(1000);

    // A request held during a ramp is ignored.
    do_req(4'b0000);
    req_valid = 1'b1;
    req_sel = 4'b1111;
    hold_req = 1;
    finish_ramp(1000);
    tick();
    chk("held_req_ignored", int'(busy), 0);
    chk("held_req_sel", int'(div_sel), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
